// File: rtl/tdm_demultiplexer_if.sv
// Bus between an upstream TDM sample source and the demultiplexer.
//   din, din_valid, frame_sync : serial sample stream from upstream
//   a..h                       : channel 0..7 data of the last complete frame
//   sel                        : channel index of the next valid sample
//   frame_valid, sync_err      : one-cycle status pulses
//   locked                     : high while frames are being captured
interface tdm_demultiplexer_if #(
    parameter int unsigned W = 1
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    logic [2:0]   sel;
    logic         frame_valid;
    logic         sync_err;
    logic         locked;

    modport master (
        output din, din_valid, frame_sync,
        input  a, b, c, d, e, f, g, h, sel, frame_valid, sync_err, locked
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output a, b, c, d, e, f, g, h, sel, frame_valid, sync_err, locked
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// Receive end of an 8-channel TDM link. Tracks frame position, collects
// channels 0..6 into shadow registers and updates all eight outputs at once
// when channel 7 arrives. Loss of alignment pulses sync_err and resyncs.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of tdm_demultiplexer_if (stream in, channels/status out)
module tdm_demultiplexer #(
    parameter int unsigned W = 1
) (
    input logic               clk,
    input logic               rst_n,
    tdm_demultiplexer_if.slave bus
);
    typedef enum logic {HUNT, CAPTURE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [6:0][W-1:0]  shadow_q, shadow_d;
    logic [7:0][W-1:0]  ch_q, ch_d;
    logic               fv_q, fv_d;
    logic               se_q, se_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            sel_q    <= '0;
            shadow_q <= '0;
            ch_q     <= '0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            ch_q     <= ch_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        ch_d     = ch_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
        if (bus.din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        shadow_d[0] = bus.din;
                        sel_d       = 3'd1;
                        state_d     = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.frame_sync) begin
                        // Normal boundary at sel=0; anywhere else the partial
                        // frame is dropped and this sample starts a new one.
                        shadow_d[0] = bus.din;
                        sel_d       = 3'd1;
                        se_d        = (sel_q != 3'd0);
                    end else if (sel_q == 3'd0) begin
                        se_d    = 1'b1;
                        state_d = HUNT;
                    end else if (sel_q == 3'd7) begin
                        ch_d  = {bus.din, shadow_q};
                        fv_d  = 1'b1;
                        sel_d = 3'd0;
                    end else begin
                        for (int unsigned k = 1; k < 7; k++) begin
                            if (sel_q == 3'(k)) shadow_d[k] = bus.din;
                        end
                        sel_d = sel_q + 3'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bus.a           = ch_q[0];
    assign bus.b           = ch_q[1];
    assign bus.c           = ch_q[2];
    assign bus.d           = ch_q[3];
    assign bus.e           = ch_q[4];
    assign bus.f           = ch_q[5];
    assign bus.g           = ch_q[6];
    assign bus.h           = ch_q[7];
    assign bus.sel         = sel_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.locked      = (state_q == CAPTURE);
endmodule

// File: tb/tb_tdm_demultiplexer.sv
module tb_tdm_demultiplexer;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    tdm_demultiplexer_if #(.W(4)) bus ();

    tdm_demultiplexer #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0][3:0] e);
        logic [7:0][3:0] o;
        o = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
        for (int i = 0; i < 8; i++) chk($sformatf("%s_ch%0d", tag, i), 32'(o[i]), 32'(e[i]));
    endtask

    task automatic chk_status(input string tag, input logic [2:0] s, input logic fv,
                              input logic se, input logic lk);
        chk({tag, "_sel"}, 32'(bus.sel), 32'(s));
        chk({tag, "_fv"}, 32'(bus.frame_valid), 32'(fv));
        chk({tag, "_se"}, 32'(bus.sync_err), 32'(se));
        chk({tag, "_locked"}, 32'(bus.locked), 32'(lk));
    endtask

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic [3:0] v, input logic fs, input logic vld);
        bus.din        = v;
        bus.frame_sync = fs;
        bus.din_valid  = vld;
        @(posedge clk);
        #1;
    endtask

    // Full aligned frame, sync on channel 0, checking sel and pulses per sample.
    task automatic send_frame(input string tag, input logic [7:0][3:0] fr);
        for (int i = 0; i < 8; i++) begin
            step(fr[i], i == 0, 1'b1);
            chk_status($sformatf("%s_s%0d", tag, i), 3'((i + 1) % 8), i == 7, 1'b0, 1'b1);
        end
    endtask

    logic [7:0][3:0] basic_f, frame_a, frame_b, resync_f, clean_f;

    initial begin
        basic_f  = {4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1};
        frame_a  = {4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
        frame_b  = {4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        resync_f = {4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h9};
        clean_f  = {4'h6, 4'h2, 4'h9, 4'h5, 4'h1, 4'h4, 4'h1, 4'h3};

        // Reset, then HUNT discards unsynced samples silently.
        rst_n = 1'b0;
        step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        chk_status("rst", 3'd0, 1'b0, 1'b0, 1'b0);
        chk_outs("rst", '0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 1'b0, 1'b1);
            chk_status($sformatf("hunt%0d", i), 3'd0, 1'b0, 1'b0, 1'b0);
        end
        chk_outs("hunt", '0);

        // Basic frame 1,0,1,1,0,0,1,0.
        send_frame("basic", basic_f);
        chk_outs("basic", basic_f);

        // Frame A continuous, frame B with a 3-cycle gap after channel 3.
        send_frame("fa", frame_a);
        chk_outs("fa", frame_a);
        for (int i = 0; i < 4; i++) begin
            step(frame_b[i], i == 0, 1'b1);
            chk_status($sformatf("fb_s%0d", i), 3'(i + 1), 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 1'b1, 1'b0);
            chk_status($sformatf("fb_gap%0d", i), 3'd4, 1'b0, 1'b0, 1'b1);
            chk_outs($sformatf("fb_gap%0d", i), frame_a);
        end
        for (int i = 4; i < 8; i++) begin
            step(frame_b[i], 1'b0, 1'b1);
            chk_status($sformatf("fb_s%0d", i), 3'((i + 1) % 8), i == 7, 1'b0, 1'b1);
        end
        chk_outs("fb", frame_b);

        // Early sync after 4 samples of an abandoned frame.
        step(4'hA, 1'b1, 1'b1);
        step(4'hB, 1'b0, 1'b1);
        step(4'hC, 1'b0, 1'b1);
        step(4'hD, 1'b0, 1'b1);
        chk_status("early_pre", 3'd4, 1'b0, 1'b0, 1'b1);
        step(4'h9, 1'b1, 1'b1);
        chk_status("early_err", 3'd1, 1'b0, 1'b1, 1'b1);
        chk_outs("early_err", frame_b);
        for (int i = 1; i < 8; i++) begin
            step(4'(i), 1'b0, 1'b1);
            chk_status($sformatf("early_s%0d", i), 3'((i + 1) % 8), i == 7, 1'b0, 1'b1);
            if (i < 7) chk_outs($sformatf("early_hold%0d", i), frame_b);
        end
        chk_outs("early", resync_f);

        // Missing sync right after a completed frame.
        step(4'h5, 1'b0, 1'b1);
        chk_status("miss", 3'd0, 1'b0, 1'b1, 1'b0);
        chk_outs("miss", resync_f);
        step(4'h0, 1'b0, 1'b0);
        chk_status("miss_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 5; i++) step(4'(i + 2), i == 0, 1'b1);
        chk_status("mid_pre", 3'd5, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk_status("mid_rst", 3'd0, 1'b0, 1'b0, 1'b0);
        chk_outs("mid_rst", '0);
        send_frame("clean", clean_f);
        chk_outs("clean", clean_f);
        step(4'h0, 1'b0, 1'b0);
        chk_status("clean_idle", 3'd0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
